// File: rtl/load_arbiter_pkg.sv
// rtl/load_arbiter_pkg.sv - shared constants and FSM encoding for the load arbiter
package load_arbiter_pkg;

   localparam int DEF_NREQ      = 4;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_BURST = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/load_arbiter_rr_pick.sv
// rtl/load_arbiter_rr_pick.sv - round-robin search starting one past ptr
module rr_pick
   import load_arbiter_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic                    valid,
   output logic [$clog2(NREQ)-1:0] index
);

   localparam int IW = $clog2(NREQ);

   // Walk the search order backwards so the last hit is the first in round-robin order.
   always_comb begin
      logic [IW-1:0] cand;
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = IW'((int'(ptr) + i) % NREQ);
         if (req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/load_arbiter.sv
// rtl/load_arbiter.sv - round-robin arbiter with bounded bursts driving a shared loadable register
module load_arbiter
   import load_arbiter_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         ack,
   output logic                    load,
   output logic [WIDTH-1:0]        d_in,
   output logic [$clog2(NREQ)-1:0] grant_id
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

   arb_state_e       state;
   arb_state_e       state_next;
   logic [IW-1:0]    ptr;
   logic [BW-1:0]    burst_cnt;

   logic             rr_valid;
   logic [IW-1:0]    rr_index;
   logic             grant;
   logic [IW-1:0]    grant_idx;
   logic [BW-1:0]    burst_next;
   logic             owner_req;
   logic             others_req;
   logic [WIDTH-1:0] data_arr [NREQ];

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (rr_valid),
      .index (rr_index)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (|req)  state_next = ST_OWN;
         ST_OWN:  if (!(|req)) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // In OWN, ptr equals grant_id, so the rr search naturally visits the owner last.
   always_comb begin
      owner_req  = (state == ST_OWN) && req[grant_id];
      others_req = |(req & ~(ONE_HOT0 << grant_id));
      grant      = 1'b0;
      grant_idx  = rr_index;
      burst_next = burst_cnt;
      if (owner_req && (burst_cnt < BURST_LAST)) begin
         grant      = 1'b1;
         grant_idx  = grant_id;
         burst_next = burst_cnt + 1'b1;
      end else if (owner_req && !others_req) begin
         grant      = 1'b1;
         grant_idx  = grant_id;
         burst_next = burst_cnt;
      end else if (rr_valid) begin
         grant      = 1'b1;
         grant_idx  = rr_index;
         burst_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= IW'(NREQ - 1);
         burst_cnt <= '0;
         ack       <= '0;
         load      <= 1'b0;
         d_in      <= '0;
         grant_id  <= '0;
      end else begin
         load <= grant;
         ack  <= grant ? (ONE_HOT0 << grant_idx) : '0;
         if (grant) begin
            ptr       <= grant_idx;
            grant_id  <= grant_idx;
            d_in      <= data_arr[grant_idx];
            burst_cnt <= burst_next;
         end
      end
   end

endmodule

// File: tb/tb_load_arbiter.sv
// tb/tb_load_arbiter.sv - directed self-checking bench for load_arbiter
module tb_load_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;

   logic [3:0]  ack, ack_b1;
   logic        load, load_b1;
   logic [7:0]  d_in, d_in_b1;
   logic [1:0]  grant_id, grant_id_b1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   load_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .data     (data),
      .ack      (ack),
      .load     (load),
      .d_in     (d_in),
      .grant_id (grant_id)
   );

   load_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(1)) dut_b1 (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .data     (data),
      .ack      (ack_b1),
      .load     (load_b1),
      .d_in     (d_in_b1),
      .grant_id (grant_id_b1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] seq_d [5];
      logic [3:0] seq_a [5];
      logic [7:0] seq_d4 [5];
      logic [1:0] w;
      seq_d  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      seq_a  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      seq_d4 = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22};

      // reset with requests present: they must be discarded
      rst = 1'b1; req = 4'b1111; data = 32'h44332211;
      step();
      check("rst_load", 32'(load), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_d_in", 32'(d_in), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);
      rst = 1'b0; req = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         step();
         check("idle_load", 32'(load), 32'd0);
         check("idle_ack", 32'(ack), 32'd0);
         check("idle_d_in", 32'(d_in), 32'd0);
      end

      // all requesting: MAX_BURST=1 rotates, MAX_BURST=4 bursts
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         check("rot_d_in", 32'(d_in_b1), 32'(seq_d[k]));
         check("rot_ack", 32'(ack_b1), 32'(seq_a[k]));
         check("burst_d_in", 32'(d_in), 32'(seq_d4[k]));
      end
      req = 4'b0000;
      step();
      check("hold_load", 32'(load), 32'd0);
      check("hold_d_in", 32'(d_in), 32'h22);
      check("hold_gid", 32'(grant_id), 32'd1);
      check("hold_gid_b1", 32'(grant_id_b1), 32'd0);
      check("hold_d_in_b1", 32'(d_in_b1), 32'h11);

      // lone requester: no forced rotation
      data = 32'h00A50000; req = 4'b0100;
      for (int k = 0; k < 6; k++) begin
         step();
         check("solo_load", 32'(load), 32'd1);
         check("solo_ack", 32'(ack), 32'b0100);
         check("solo_d_in", 32'(d_in), 32'hA5);
      end
      req = 4'b0000;
      step();
      check("solo_end", 32'(load), 32'd0);

      // two requesters: bursts of 4 alternate
      rst = 1'b1; step(); rst = 1'b0;
      data = 32'h44332211; req = 4'b1001;
      for (int k = 0; k < 16; k++) begin
         step();
         w = ((k / 4) % 2 == 0) ? 2'd0 : 2'd3;
         check("alt4_gid", 32'(grant_id), 32'(w));
         check("alt4_ack", 32'(ack), 32'(4'b0001 << w));
         w = (k % 2 == 0) ? 2'd0 : 2'd3;
         check("alt1_gid", 32'(grant_id_b1), 32'(w));
      end

      // reset aborts a burst; next grant goes to lowest asserted
      rst = 1'b1; step(); rst = 1'b0;
      req = 4'b1000;
      step(); step();
      req = 4'b1010;
      step();
      check("pre_rst_ack", 32'(ack), 32'b1000);
      rst = 1'b1;
      step();
      check("abort_load", 32'(load), 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_ack", 32'(ack), 32'b0010);
      check("post_rst_gid", 32'(grant_id), 32'd1);

      // single-cycle pulse
      req = 4'b0000;
      step();
      data = 32'h00005A00; req = 4'b0010;
      step();
      check("pulse_load", 32'(load), 32'd1);
      check("pulse_ack", 32'(ack), 32'b0010);
      check("pulse_d_in", 32'(d_in), 32'h5A);
      req = 4'b0000;
      step();
      check("pulse_after_load", 32'(load), 32'd0);
      check("pulse_after_ack", 32'(ack), 32'd0);
      check("pulse_after_gid", 32'(grant_id), 32'd1);
      check("pulse_after_d_in", 32'(d_in), 32'h5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (load !== (|ack)) begin
            n_errors++;
            $display("FAIL load_or_ack: got %0b expected %0b", load, |ack);
         end
         if (!$onehot0(ack)) begin
            n_errors++;
            $display("FAIL ack_onehot: got %0b expected onehot0", ack);
         end
      end
   end

endmodule

// File: doc/load_arbiter.md
LOAD_ARBITER -- requirements
Module: load_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the data width of the shared loadable register.
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive grants to one requester while others are waiting (>=1).
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NREQ  per-requester write request, level.
REQ-007 data  input  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
REQ-008 ack  output  NREQ  one-hot grant acknowledge, registered.
REQ-009 load  output  1  load enable to the shared register, registered.
REQ-010 d_in  output  WIDTH  data to the shared register, registered.
REQ-011 grant_id  output  $clog2(NREQ)  index of the last granted requester, registered.

Function
REQ-012 At each edge, the block SHALL sample req and data, choose at most one winner, and drive load=1, ack[winner]=1 and d_in=data[winner] for exactly the following cycle; latency is 1 cycle from sampled req to load.
REQ-013 With req all zero, the block SHALL drive load=0 and ack=0 next cycle, and d_in and grant_id SHALL hold their values.
REQ-014 Winner selection SHALL be round-robin: search starts at (ptr+1) mod NREQ, wraps past NREQ-1 to 0, and picks the first asserted req.
REQ-015 ptr SHALL update to the winner index on every grant.
REQ-016 FSM states: IDLE (no grant last cycle) and OWN (grant issued last cycle). IDLE->OWN on any req; OWN->IDLE on req all zero; OWN->OWN otherwise.
REQ-017 In OWN, if req[grant_id] is still high, the same requester SHALL be re-granted (burst) while burst_cnt < MAX_BURST-1, regardless of other requests.
REQ-018 burst_cnt SHALL reset to 0 on a grant to a different requester and increment on each burst re-grant.
REQ-019 When burst_cnt reaches MAX_BURST-1 and any other req is high, the grant SHALL pass round-robin to another requester; if no other req is high, the owner SHALL continue and burst_cnt SHALL stay at MAX_BURST-1.
REQ-020 A requester SHALL treat req high in the cycle ack is asserted as a new request; data SHALL be held stable while req is high and ack is low.
REQ-021 ack SHALL be one-hot or zero, and load SHALL equal OR(ack) in every cycle.

Reset
REQ-022 While rst=1 at an edge: load=0, ack=0, d_in=0, grant_id=0, ptr=NREQ-1, burst_cnt=0, state IDLE; requests sampled in that cycle SHALL be discarded.
REQ-023 Reset asserted during a burst SHALL abort it; the first grant after reset SHALL go to the lowest-index asserted req.

Structure
REQ-024 The FSM state encoding and the default NREQ/WIDTH/MAX_BURST constants SHALL live in the shared CPU package.
REQ-025 The round-robin search SHALL be one combinational sub-module, rr_pick (inputs req and ptr; outputs valid and index).
REQ-026 The design SHALL contain no latches and SHALL have no combinational path from req/data to the outputs.

Verification
REQ-027 Reset, then req=4'b0000 for 3 cycles -> load=0, ack=0, d_in=8'h00 throughout.
REQ-028 req=4'b1111 held, data={8'h44,8'h33,8'h22,8'h11}, MAX_BURST=1 -> d_in sequence 11,22,33,44,11 on consecutive cycles, ack 0001,0010,0100,1000,0001.
REQ-029 req[2] alone held 6 cycles, data[2]=8'hA5 -> load=1 for 6 consecutive cycles, ack=4'b0100, d_in=8'hA5, no forced rotation.
REQ-030 req[0] and req[3] held, MAX_BURST=4 -> 4 grants to 0, then 4 to 3, alternating; never 5 consecutive grants to either.
REQ-031 rst pulsed for 1 cycle during a burst to requester 3 while req=4'b1010 -> load=0 in the cycle after the reset edge, then the first grant goes to requester 1.
REQ-032 Single-cycle pulse on req[1] with data 8'h5A -> exactly one cycle with load=1, ack=4'b0010, d_in=8'h5A; grant_id=1 afterward.
